// File: rtl/cl_pkg.sv
// cl_pkg: shared types and helpers for the board scanner.
// States, matrix size, move-index width and "no move" code.
package cl_pkg;

  typedef enum logic [1:0] {
    OCIOSO,
    VARRE,
    CONFIRMA,
    SEGURA
  } estado_t;

  localparam int CL_NUM_LINHAS  = 8;
  localparam int CL_NUM_COLUNAS = 8;
  localparam int CL_IDX_W       = 4;

  localparam logic [CL_IDX_W-1:0] CL_SEM_JOGADA = '0;

  typedef struct packed {
    logic [2:0] linha;
    logic [2:0] coluna;
  } casa_t;

  // Pressed bits in one row, saturating at 2.
  function automatic logic [1:0] contaSat(
    input logic [CL_NUM_COLUNAS-1:0] v
  );
    logic [1:0] n;
    n = 2'd0;
    for (int i = 0; i < CL_NUM_COLUNAS; i++) begin
      if (v[i] && n != 2'd2) n = n + 2'd1;
    end
    return n;
  endfunction

  // Column of a pressed bit; meaningful when exactly one is set.
  function automatic logic [2:0] indiceBit(
    input logic [CL_NUM_COLUNAS-1:0] v
  );
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = CL_NUM_COLUNAS - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // 0-based square coordinate to the 1-based reported index.
  function automatic logic [CL_IDX_W-1:0] paraIndice(
    input logic [2:0] v
  );
    return {1'b0, v} + 4'd1;
  endfunction

endpackage

// File: rtl/varredura_tabuleiro_contador.sv
// contador_varredura: dwell and row counters of the scan.
// fimLinha marks the sample cycle, fimQuadro the row-7 sample.
module contador_varredura
  import cl_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       limpa,
  output logic [2:0] linha,
  output logic       fimLinha,
  output logic       fimQuadro
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DW-1:0] dwell;

  assign fimLinha  = (dwell == DW'(SCAN_DIV - 1));
  assign fimQuadro = fimLinha &&
                     (linha == 3'(CL_NUM_LINHAS - 1));

  // Dwell on each row, then step; row 7 wraps to 0.
  always_ff @(posedge clock) begin
    if (reset || limpa) begin
      dwell <= '0;
      linha <= '0;
    end else if (fimLinha) begin
      dwell <= '0;
      linha <= linha + 3'd1;
    end else begin
      dwell <= dwell + 1'b1;
    end
  end

endmodule

// File: rtl/varredura_tabuleiro.sv
// varredura_tabuleiro: 8x8 board scan to single move events.
// CL_DEBOUNCE_EN enables multi-frame confirmation (CONFIRMA).
module varredura_tabuleiro
  import cl_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      habilita,
  input  logic [CL_NUM_COLUNAS-1:0] coluna_sensor,
  output logic [CL_NUM_LINHAS-1:0]  linha_sel,
  output logic [CL_IDX_W-1:0]       jogadaFileira,
  output logic [CL_IDX_W-1:0]       jogadaColuna,
  output logic                      temJogada,
  output logic [2:0]                db_varredura
);

  estado_t    estado;
  logic       limpa;
  logic [2:0] linha;
  logic       fimLinha;
  logic       fimQuadro;

  logic [1:0] accConta;
  logic [1:0] baseConta;
  logic [1:0] linhaConta;
  logic [1:0] quadroConta;
  logic [2:0] soma;
  casa_t      accCasa;
  casa_t      quadroCasa;
  logic       quadroUnico;
  logic       quadroVazio;

`ifdef CL_DEBOUNCE_EN
  localparam logic [7:0] DEB = 8'(DEBOUNCE_SCANS);
  casa_t      candidato;
  logic [7:0] contaEstavel;
`endif

  assign limpa = (estado == OCIOSO) || !habilita;

  contador_varredura #(
    .SCAN_DIV (SCAN_DIV)
  ) uCont (
    .clock     (clock),
    .reset     (reset),
    .limpa     (limpa),
    .linha     (linha),
    .fimLinha  (fimLinha),
    .fimQuadro (fimQuadro)
  );

  assign linha_sel = (estado == OCIOSO) ? '0
                   : (CL_NUM_LINHAS'(1) << linha);
  assign db_varredura = linha;

  // Frame totals including the row being sampled now.
  always_comb begin
    linhaConta  = contaSat(coluna_sensor);
    baseConta   = (linha == 3'd0) ? 2'd0 : accConta;
    soma        = {1'b0, baseConta} + {1'b0, linhaConta};
    quadroConta = (soma > 3'd2) ? 2'd2 : soma[1:0];
    quadroCasa  = accCasa;
    if (baseConta == 2'd0 && linhaConta == 2'd1) begin
      quadroCasa.linha  = linha;
      quadroCasa.coluna = indiceBit(coluna_sensor);
    end
  end

  assign quadroUnico = fimQuadro && (quadroConta == 2'd1);
  assign quadroVazio = fimQuadro && (quadroConta == 2'd0);

  // Per-frame accumulator; row 0 restarts it implicitly.
  always_ff @(posedge clock) begin
    if (reset || limpa) begin
      accConta <= 2'd0;
      accCasa  <= '0;
    end else if (fimLinha) begin
      accConta <= quadroConta;
      accCasa  <= quadroCasa;
    end
  end

  // Scan FSM with registered move outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado        <= OCIOSO;
      temJogada     <= 1'b0;
      jogadaFileira <= CL_SEM_JOGADA;
      jogadaColuna  <= CL_SEM_JOGADA;
`ifdef CL_DEBOUNCE_EN
      candidato     <= '0;
      contaEstavel  <= 8'd0;
`endif
    end else begin
      temJogada <= 1'b0;
      if (!habilita) begin
        estado <= OCIOSO;
      end else begin
        unique case (estado)
          OCIOSO: estado <= VARRE;
          VARRE: begin
            if (quadroUnico) begin
`ifdef CL_DEBOUNCE_EN
              candidato    <= quadroCasa;
              contaEstavel <= 8'd1;
              if (DEB <= 8'd1) begin
                temJogada     <= 1'b1;
                jogadaFileira <= paraIndice(quadroCasa.linha);
                jogadaColuna  <= paraIndice(quadroCasa.coluna);
                estado        <= SEGURA;
              end else begin
                estado <= CONFIRMA;
              end
`else
              temJogada     <= 1'b1;
              jogadaFileira <= paraIndice(quadroCasa.linha);
              jogadaColuna  <= paraIndice(quadroCasa.coluna);
              estado        <= SEGURA;
`endif
            end
          end
          CONFIRMA: begin
`ifdef CL_DEBOUNCE_EN
            if (fimQuadro) begin
              if (quadroConta != 2'd1) begin
                estado <= VARRE;
              end else if (quadroCasa != candidato) begin
                candidato    <= quadroCasa;
                contaEstavel <= 8'd1;
              end else if (contaEstavel + 8'd1 >= DEB) begin
                temJogada     <= 1'b1;
                jogadaFileira <= paraIndice(quadroCasa.linha);
                jogadaColuna  <= paraIndice(quadroCasa.coluna);
                estado        <= SEGURA;
              end else begin
                contaEstavel <= contaEstavel + 8'd1;
              end
            end
`else
            estado <= VARRE;
`endif
          end
          SEGURA: begin
            if (quadroVazio) estado <= VARRE;
          end
          default: estado <= OCIOSO;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_varredura_tabuleiro.sv
// tb_varredura_tabuleiro: directed scan/debounce scenarios.
// Expected pulses are queued; a monitor pops them on temJogada.
module tb_varredura_tabuleiro;

  localparam int SD     = 4;
  localparam int DB     = 2;
  localparam int QUADRO = 8 * SD;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       habilita = 1'b0;
  logic [7:0] coluna_sensor;
  logic [7:0] linha_sel;
  logic [3:0] jogadaFileira;
  logic [3:0] jogadaColuna;
  logic       temJogada;
  logic [2:0] db_varredura;

  logic [7:0] tab [8];
  logic [7:0] fila [$];
  logic [7:0] esp;

  int passou    = 0;
  int total     = 0;
  int nPulsos   = 0;
  int espPulsos = 0;

  varredura_tabuleiro #(
    .SCAN_DIV       (SD),
    .DEBOUNCE_SCANS (DB)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .habilita      (habilita),
    .coluna_sensor (coluna_sensor),
    .linha_sel     (linha_sel),
    .jogadaFileira (jogadaFileira),
    .jogadaColuna  (jogadaColuna),
    .temJogada     (temJogada),
    .db_varredura  (db_varredura)
  );

  always #5 clock = ~clock;

  // Board model: driven row selects its column pattern.
  always_comb begin
    coluna_sensor = '0;
    for (int i = 0; i < 8; i++) begin
      if (linha_sel[i]) coluna_sensor = coluna_sensor | tab[i];
    end
  end

  task automatic chk(input string nome, input int atual,
                     input int esperado);
    total++;
    if (atual == esperado) passou++;
    else $display("FAIL %s: got %0d expected %0d",
                  nome, atual, esperado);
  endtask

  // Monitor: every pulse must match the oldest expectation.
  always @(negedge clock) begin
    if (!reset && temJogada) begin
      nPulsos++;
      if (fila.size() == 0) begin
        total++;
        $display("FAIL pulso_inesperado: got %0d/%0d expected none",
                 jogadaFileira, jogadaColuna);
      end else begin
        esp = fila.pop_front();
        chk("pulso_indices", {jogadaFileira, jogadaColuna}, esp);
      end
    end
  end

  task automatic esperar(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic espera(input logic [3:0] f, input logic [3:0] c);
    fila.push_back({f, c});
    espPulsos++;
  endtask

  // Return at cycle 0 of a frame (row 0 just started).
  task automatic alinhar();
    logic [7:0] ant;
    int ok;
    ok  = 0;
    ant = linha_sel;
    for (int i = 0; i < 4 * QUADRO && ok == 0; i++) begin
      @(posedge clock);
      #1;
      if (linha_sel == 8'h01 && ant == 8'h80) ok = 1;
      ant = linha_sel;
    end
    chk("alinhar", ok, 1);
  endtask

  task automatic fimFase(input string nome);
    chk({nome, "_npulsos"}, nPulsos, espPulsos);
    chk({nome, "_fila"}, fila.size(), 0);
    fila.delete();
    espPulsos = nPulsos;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) tab[i] = 8'h00;
    reset    = 1'b1;
    habilita = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_linha_sel", linha_sel, 0);
    chk("rst_fileira", jogadaFileira, 0);
    chk("rst_coluna", jogadaColuna, 0);
    chk("rst_temJogada", temJogada, 0);
    chk("rst_db", db_varredura, 0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      for (int k = 0; k < SD; k++) begin
        @(posedge clock);
        #1;
        chk("passo_linha_sel", linha_sel, 1 << (i % 8));
        if (k == 0) chk("passo_db", db_varredura, i % 8);
      end
    end

    // Single press at (2,4), held then released.
    alinhar();
    espera(4'd3, 4'd5);
    tab[2] = 8'h10;
    esperar(5 * QUADRO);
    fimFase("peca_24");
    tab[2] = 8'h00;
    esperar(2 * QUADRO);
    chk("solta_fileira", jogadaFileira, 3);
    chk("solta_coluna", jogadaColuna, 5);
    fimFase("solta_24");

    // Two squares together never report.
    alinhar();
    tab[2] = 8'h10;
    tab[6] = 8'h01;
    esperar(10 * QUADRO);
    tab[2] = 8'h00;
    tab[6] = 8'h00;
    esperar(2 * QUADRO);
    fimFase("multi");
    chk("multi_fileira", jogadaFileira, 3);
    chk("multi_coluna", jogadaColuna, 5);

    // One-frame glitch at (5,7).
    alinhar();
`ifndef CL_DEBOUNCE_EN
    espera(4'd6, 4'd8);
`endif
    tab[5] = 8'h80;
    esperar(QUADRO);
    tab[5] = 8'h00;
    esperar(3 * QUADRO);
    fimFase("transitorio");
`ifdef CL_DEBOUNCE_EN
    chk("trans_fileira", jogadaFileira, 3);
    chk("trans_coluna", jogadaColuna, 5);
`else
    chk("trans_fileira", jogadaFileira, 6);
    chk("trans_coluna", jogadaColuna, 8);
`endif

    // Disable mid-confirmation, then re-enable.
    alinhar();
`ifndef CL_DEBOUNCE_EN
    espera(4'd2, 4'd2);
`endif
    tab[1] = 8'h02;
    esperar(QUADRO);
    habilita = 1'b0;
    esperar(1);
    chk("desab_linha_sel", linha_sel, 0);
    chk("desab_db", db_varredura, 0);
    esperar(4);
    chk("desab_temJogada", temJogada, 0);
    fimFase("desabilita");
    habilita = 1'b1;
    espera(4'd2, 4'd2);
    esperar(1);
    chk("reab_linha_sel", linha_sel, 8'h01);
    esperar(4 * QUADRO);
    fimFase("reabilita");
    tab[1] = 8'h00;
    esperar(2 * QUADRO);

    // Same square twice with one empty frame between.
    alinhar();
    espera(4'd4, 4'd4);
    tab[3] = 8'h08;
    esperar(3 * QUADRO);
    tab[3] = 8'h00;
    esperar(QUADRO);
    espera(4'd4, 4'd4);
    tab[3] = 8'h08;
    esperar(3 * QUADRO);
    fimFase("repete_33");
    chk("repete_fileira", jogadaFileira, 4);
    chk("repete_coluna", jogadaColuna, 4);

    $display("%0d/%0d checks passed", passou, total);
    $finish;
  end

endmodule

// File: doc/varredura_tabuleiro.md
# varredura_tabuleiro

Scans the 8x8 sensor matrix of the physical chess board and turns one new piece placement into a single move event for the game datapath. It drives one row at a time, samples the column lines, and debounces across full scan frames. It then reports the square as 1-based row/column indices with a one-cycle `temJogada` pulse. It sits directly upstream of the game top level and feeds its `jogadaFileira`, `jogadaColuna` and `temJogada` inputs.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each row is driven (dwell); must be ≥ 2.
- `DEBOUNCE_SCANS`, default 4: consecutive identical valid frames required before reporting; must be ≥ 1.
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `habilita`  in  1  enables scanning; low parks the block idle.
- `coluna_sensor`  in  8  column reads for the driven row; bit c high = square (row, c) occupied/pressed.
- `linha_sel`  out  8  one-hot row drive; all-zero when idle.
- `jogadaFileira`  out  4  reported row, 1..8; 0 = none since reset.
- `jogadaColuna`  out  4  reported column, 1..8 (1 = file A); 0 = none since reset.
- `temJogada`  out  1  one-cycle pulse marking a new report.
- `db_varredura`  out  3  current row index 0..7, for debug.

## Operation
- Row counter r (0..7) and dwell counter d (0..SCAN_DIV-1). `linha_sel` = 1<<r while scanning.
- `coluna_sensor` sampled only on the cycle d = SCAN_DIV-1. Then d→0 and r→r+1 (7 wraps to 0).
- A frame is the 8 samples r=0..7. Per frame, count pressed bits (saturating at 2) and record the (r,c) of the pressed bit.
- Frame class: EMPTY (0 bits), SINGLE (exactly 1 bit), MULTI (≥2 bits).
- FSM states:
  - OCIOSO: `linha_sel`=0, counters held at 0. Goes to VARRE when `habilita`=1.
  - VARRE: SINGLE frame → latch candidate, stable count=1 → CONFIRMA. EMPTY or MULTI → stay.
  - CONFIRMA: SINGLE with the same square → count+1. SINGLE with a different square → new candidate, count=1. EMPTY or MULTI → VARRE. When count reaches DEBOUNCE_SCANS → report → SEGURA.
  - SEGURA: the move has been reported. Only an EMPTY frame → VARRE, so a held piece never re-reports.
- `habilita`=0 in any state → OCIOSO next cycle. The partial frame and candidate are discarded; no pulse.
- Report: `jogadaFileira`=r+1, `jogadaColuna`=c+1, `temJogada`=1 for that one cycle. The indices hold until the next report or reset.
- `reset` has priority over `habilita`.
- Reset values: state OCIOSO, r=0, d=0, `linha_sel`=0, `jogadaFileira`=0, `jogadaColuna`=0, `temJogada`=0, `db_varredura`=0.

## Timing
- Frame length is 8·SCAN_DIV cycles. Frame classification is complete on the cycle the row-7 sample is taken. The state transition happens on the next edge.
- `temJogada` and the new indices appear together, one cycle after the row-7 sample closing the confirming frame.
- Latency from a clean press to the pulse: at most (DEBOUNCE_SCANS+1)·8·SCAN_DIV + 1 cycles.
- Enabling from OCIOSO: row 0 is driven starting the cycle after `habilita` is seen high.
- Frames are always aligned to r=0; no partial first frame counts.

## Configuration
- `CL_DEBOUNCE_EN` defined: behaviour as above.
- `CL_DEBOUNCE_EN` not defined: `DEBOUNCE_SCANS` is ignored and CONFIRMA is not implemented.
  - A SINGLE frame in VARRE reports immediately and goes to SEGURA.
  - Latency is at most 2 frames + 1 cycle.
  - SEGURA release rule is unchanged.

## Structure
- Shared package `cl_pkg`:
  - FSM state enum (OCIOSO, VARRE, CONFIRMA, SEGURA).
  - `CL_NUM_LINHAS`=8 and `CL_NUM_COLUNAS`=8.
  - The 4-bit index width, and the "no move" code 0.
- One sub-module, `contador_varredura`:
  - Contains the dwell and row counters.
  - Outputs r, `fim_linha` (d = SCAN_DIV-1) and `fim_quadro` (`fim_linha` with r=7).
  - Has a synchronous clear input, driven in OCIOSO.

## Test plan
(SCAN_DIV=4, DEBOUNCE_SCANS=2, so a frame is 32 cycles.)
- Reset held 3 cycles, `habilita`=1 → all outputs 0. After release, `linha_sel`=8'h01 and it steps every 4 cycles, 8'h80 wrapping to 8'h01.
- Square (r=2,c=4) held continuously → exactly one `temJogada` pulse with `jogadaFileira`=3 and `jogadaColuna`=5. No further pulse while held. Indices still 3/5 after release.
- (2,4) and (6,0) pressed together for 10 frames → no pulse. Indices unchanged.
- (5,7) present for 1 frame only, then released → no pulse with the macro. Without the macro: pulse with indices 6/8.
- Candidate (1,1) confirmed 1 frame, then `habilita`=0 → next cycle `linha_sel`=0 and no pulse. Re-enable → full debounce restarts, then pulse with 2/2.
- Report (3,3), release for one EMPTY frame, press (3,3) again → second pulse with 4/4.
